// File: rtl/multdiv_sequencer_pkg.sv
// multdiv_sequencer_pkg
//   Shared processor constants for the multdiv sequencer: FSM state
//   encoding, default watchdog limit and the counter-width helper.
//   No ports (package).

package multdiv_sequencer_pkg;

    // Default watchdog limit, in cycles, on one multdiv operation.
    localparam int MD_MAX_CYCLES_DEFAULT = 40;

    // Sequencer FSM state encoding.
    localparam int         MD_STATE_W = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_BUSY    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // ceil(log2(max_cycles)); a one-bit floor keeps degenerate limits legal.
    function automatic int md_cnt_width(input int max_cycles);
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if
//   Bundles the X-stage request, the multdiv unit handshake and the
//   result/stall signals of the multdiv sequencer.
//   Modports:
//     master - pipeline / multdiv-unit side (drives op_*, md_result,
//              md_exception, md_rdy; observes everything else)
//     slave  - the sequencer itself

interface multdiv_sequencer_if;

    // X-stage request
    logic        op_valid;
    logic        op_is_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  op_rd;

    // multdiv unit handshake
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_rdy;

    // pipeline control and result
    logic        stall;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_exc;

    modport master (
        output op_valid, op_is_div, op_a, op_b, op_rd,
        output md_result, md_exception, md_rdy,
        input  md_ctrl_mult, md_ctrl_div, md_a, md_b,
        input  stall, res_valid, res_data, res_rd, res_exc
    );

    modport slave (
        input  op_valid, op_is_div, op_a, op_b, op_rd,
        input  md_result, md_exception, md_rdy,
        output md_ctrl_mult, md_ctrl_div, md_a, md_b,
        output stall, res_valid, res_data, res_rd, res_exc
    );

endinterface

// File: rtl/multdiv_sequencer_md_watchdog_counter.sv
// md_watchdog_counter
//   Up-counter bounding the number of BUSY cycles of one multdiv
//   operation. Saturates at MAX_CYCLES-1, so it can never wrap.
//   Ports:
//     clock            - rising-edge clock
//     reset            - asynchronous, active-low reset (count -> 0)
//     i_clear          - synchronous clear to 0 (has priority)
//     i_enable         - count up by one this cycle
//     o_terminal_count - count equals MAX_CYCLES-1

module md_watchdog_counter
    import multdiv_sequencer_pkg::*;
#(
    parameter int MAX_CYCLES = MD_MAX_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal_count
);

    localparam int               CNT_W  = md_cnt_width(MAX_CYCLES);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_tc;

    assign w_tc = (r_count == TC_VAL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_tc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_terminal_count = w_tc;

endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//   Sequences one multiply or divide through the multi-cycle multdiv
//   unit: freezes the pipeline, latches the X-stage operands, pulses the
//   unit's start, waits for md_rdy (bounded by a watchdog) and hands the
//   result to the XM latch as a one-cycle pulse.
//   Ports:
//     clock - rising-edge clock
//     reset - asynchronous, active-low reset
//     md_if - multdiv_sequencer_if.slave (request, unit handshake, result)
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for op_valid; operands latched when it is seen
//   START | one-cycle md_ctrl_mult/md_ctrl_div pulse, watchdog cleared
//   BUSY  | counting cycles until md_rdy or watchdog terminal count
//   DONE  | res_valid pulse, stall released, op_valid ignored

module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int MAX_CYCLES = MD_MAX_CYCLES_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_sequencer_if.slave   md_if
);

    logic [MD_STATE_W-1:0] r_state;
    logic [MD_STATE_W-1:0] w_state_nxt;

    logic        r_is_div;
    logic [4:0]  r_op_rd;
    logic [31:0] r_md_a;
    logic [31:0] r_md_b;
    logic [31:0] r_res_data;
    logic [4:0]  r_res_rd;
    logic        r_res_exc;

    logic w_idle;
    logic w_start;
    logic w_busy;
    logic w_done;
    logic w_accept;
    logic w_capture;
    logic w_timeout;
    logic w_tc;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_start = (r_state == ST_START);
    assign w_busy  = (r_state == ST_BUSY);
    assign w_done  = (r_state == ST_DONE);

    assign w_accept  = w_idle & md_if.op_valid;
    // md_rdy wins over a simultaneous watchdog expiry.
    assign w_capture = w_busy & md_if.md_rdy;
    assign w_timeout = w_busy & ~md_if.md_rdy & w_tc;

    md_watchdog_counter #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_md_watchdog_counter (
        .clock            (clock),
        .reset            (reset),
        .i_clear          (w_start),
        .i_enable         (w_busy),
        .o_terminal_count (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (md_if.op_valid) w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_BUSY;
            ST_BUSY:  if (md_if.md_rdy || w_tc) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_op_rd  <= '0;
            r_md_a   <= '0;
            r_md_b   <= '0;
        end else if (w_accept) begin
            r_is_div <= md_if.op_is_div;
            r_op_rd  <= md_if.op_rd;
            r_md_a   <= md_if.op_a;
            r_md_b   <= md_if.op_b;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_res_data <= '0;
            r_res_rd   <= '0;
            r_res_exc  <= 1'b0;
        end else if (w_capture) begin
            r_res_data <= md_if.md_result;
            r_res_rd   <= r_op_rd;
            r_res_exc  <= md_if.md_exception;
        end else if (w_timeout) begin
            r_res_data <= '0;
            r_res_rd   <= r_op_rd;
            r_res_exc  <= 1'b1;
        end
    end

    // The IDLE term follows op_valid combinationally, so it is gated with
    // reset to keep stall low while reset is held.
    assign md_if.stall        = reset & (w_accept | w_start | w_busy);
    assign md_if.md_ctrl_mult = w_start & ~r_is_div;
    assign md_if.md_ctrl_div  = w_start &  r_is_div;
    assign md_if.md_a         = r_md_a;
    assign md_if.md_b         = r_md_b;
    assign md_if.res_valid    = w_done;
    assign md_if.res_data     = r_res_data;
    assign md_if.res_rd       = r_res_rd;
    assign md_if.res_exc      = r_res_exc;

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 Parameter MAX_CYCLES, default 40: watchdog limit, in cycles, on one multdiv operation.
REQ-002 Port clock  in  1  master clock; all state updates on the rising edge.
REQ-003 Port reset  in  1  asynchronous, active-low reset.
REQ-004 Port op_valid  in  1  X stage holds a mult or div instruction.
REQ-005 Port op_is_div  in  1  1 = div, 0 = mult; sampled with op_valid.
REQ-006 Port op_a, op_b  in  32 each  bypassed X-stage operands.
REQ-007 Port op_rd  in  5  destination register of the X-stage instruction.
REQ-008 Port md_ctrl_mult, md_ctrl_div  out  1 each  one-cycle start pulses to the multdiv unit.
REQ-009 Port md_a, md_b  out  32 each  latched operands, held stable to the multdiv unit.
REQ-010 Port md_result  in  32; md_exception  in  1; md_rdy  in  1  multdiv unit outputs.
REQ-011 Port stall  out  1  freezes PC, FD, DX, XM and MW latch enables.
REQ-012 Port res_valid  out  1  one-cycle pulse: result is available to the XM latch.
REQ-013 Port res_data  out  32; res_rd  out  5; res_exc  out  1  result, destination and exception flag.

Function
REQ-014 The block SHALL implement the FSM states IDLE, START, BUSY and DONE.
REQ-015 IDLE with op_valid=1 SHALL latch op_a, op_b, op_is_div and op_rd, then go to START.
REQ-016 stall SHALL be combinational: (IDLE & op_valid) | START | BUSY, so the pipeline freezes in the same cycle the operation appears.
REQ-017 START SHALL assert md_ctrl_div if the latched op is div, else md_ctrl_mult, for exactly one cycle, clear the cycle counter and go to BUSY.
REQ-018 BUSY SHALL increment the counter every cycle.
REQ-019 In BUSY, md_rdy=1 SHALL capture md_result into res_data and md_exception into res_exc, then go to DONE.
REQ-020 In BUSY, if the counter reaches MAX_CYCLES-1 without md_rdy, the block SHALL go to DONE with res_data=0 and res_exc=1.
REQ-021 md_rdy and md_exception SHALL be ignored in IDLE, START and DONE.
REQ-022 If md_rdy and the timeout occur in the same cycle, md_rdy SHALL win.
REQ-023 DONE SHALL assert res_valid for one cycle with stall=0, ignore op_valid, and return to IDLE.
REQ-024 The DONE-state op_valid refers to the same retiring instruction; a new op_valid seen in the following IDLE cycle SHALL start a new operation (back-to-back supported).
REQ-025 Latency: op_valid seen at cycle 0 -> START at 1 -> BUSY from 2 -> md_rdy seen at cycle k -> res_valid at k+1.
REQ-026 md_a and md_b SHALL hold their latched values from START until the next latch in IDLE.
REQ-027 res_data, res_rd and res_exc SHALL hold their values until the next capture.
REQ-028 The counter width SHALL be ceil(log2(MAX_CYCLES)) bits and SHALL never wrap while in BUSY.

Reset
REQ-029 reset=0 SHALL force IDLE immediately, independent of clock, from any state including mid-operation.
REQ-030 During reset, every output (stall, res_valid, md_ctrl_*, md_a, md_b, res_data, res_rd, res_exc) SHALL be 0, and the counter SHALL be 0.
REQ-031 After reset releases, the first rising edge SHALL evaluate IDLE normally.

Structure
REQ-032 State encoding (2 bits) and the MAX_CYCLES default SHALL live in the shared processor package.
REQ-033 The watchdog counter SHALL be a sub-module md_watchdog_counter (inputs: clear, enable; output: terminal count); everything else stays flat.

Verification
REQ-034 Mult 6*7: op_valid at cycle 0, md_rdy at cycle 18 -> md_ctrl_mult pulse at cycle 1 only; stall 1 over cycles 0-18; res_valid at 19 with res_data=42, res_exc=0.
REQ-035 Div 100/0, unit returns md_exception=1 -> md_ctrl_div pulse at cycle 1; res_valid with res_exc=1.
REQ-036 md_rdy never asserted, MAX_CYCLES=40 -> DONE entered after 40 BUSY cycles; res_data=0, res_exc=1; stall drops.
REQ-037 Back-to-back mult then div -> two distinct res_valid pulses with one IDLE cycle between them; the second op latches the new operands.
REQ-038 reset=0 applied mid-BUSY -> stall=0 and all outputs 0 with no clock edge; a later md_rdy produces no res_valid.
REQ-039 md_rdy pulsed while in IDLE with op_valid=0 -> no state change and no res_valid.
